// File: rtl/swi_pkg.sv
// Shared constants and event record layout for the switch event capture slice.
package swi_pkg;

  localparam int unsigned NBITS_TOP = 8;
  localparam int unsigned IDX_W     = $clog2(NBITS_TOP);

  typedef struct packed {
    logic             dir;
    logic [IDX_W-1:0] idx;
  } swi_ev_t;

endpackage

// File: rtl/swi_event_capture_if.sv
// Valid/ready event queue port: {dir, idx} records flowing from capture to consumer.
interface swi_event_capture_if #(
  parameter int unsigned NBITS = swi_pkg::NBITS_TOP
);

  logic                   EV_VALID;
  logic [$clog2(NBITS):0] EV_DATA;
  logic                   EV_READY;

  modport master (
    output EV_VALID,
    output EV_DATA,
    input  EV_READY
  );

  modport slave (
    input  EV_VALID,
    input  EV_DATA,
    output EV_READY
  );

endinterface

// File: rtl/swi_debounce_bit.sv
// One switch bit: two-flop synchronizer, debounce counter and stable/rise/fall registers.
module swi_debounce_bit #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk_2,
  input  logic rst_n,
  input  logic swi,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic chg,
  output logic chg_dir
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          differ;

  assign differ  = sync2 ^ stable;
  // chg marks the edge on which stable takes the new value; the pending stage keys off it
  assign chg     = differ && (cnt == CW'(DEB_CYCLES - 1));
  assign chg_dir = sync2;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= swi;
      sync2 <= sync1;
      rise  <= chg & sync2;
      fall  <= chg & ~sync2;
      if (chg) begin
        stable <= sync2;
        cnt    <= '0;
      end else if (differ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/swi_event_capture.sv
// Debounces the SWI bank and queues one {dir, idx} event per debounced transition.
module swi_event_capture import swi_pkg::*; #(
  parameter int unsigned NBITS      = NBITS_TOP,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_2,
  input  logic                  rst_n,
  input  logic [NBITS-1:0]      SWI,
  output logic [NBITS-1:0]      SWI_STABLE,
  output logic [NBITS-1:0]      RISE,
  output logic [NBITS-1:0]      FALL,
  swi_event_capture_if.master   ev,
  output logic                  EV_OVERFLOW,
  input  logic                  OVF_CLR
);

  localparam int unsigned IW   = $clog2(NBITS);
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = PW + 1;

  typedef struct packed {
    logic          dir;
    logic [IW-1:0] idx;
  } ev_t;

  logic [NBITS-1:0] chg;
  logic [NBITS-1:0] chg_dir;
  logic [NBITS-1:0] pend;
  logic [NBITS-1:0] pdir;
  logic [NBITS-1:0] push_mask;
  logic [IW-1:0]    push_idx;
  logic             push;
  logic             pop;
  logic             ovf_set;

  ev_t              mem [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CNTW-1:0]  count;

  for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit
    swi_debounce_bit #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk_2   (clk_2),
      .rst_n   (rst_n),
      .swi     (SWI[gi]),
      .stable  (SWI_STABLE[gi]),
      .rise    (RISE[gi]),
      .fall    (FALL[gi]),
      .chg     (chg[gi]),
      .chg_dir (chg_dir[gi])
    );
  end

  // Downward scan so the lowest pending index is the last one written
  always_comb begin
    push_idx = '0;
    for (int unsigned i = NBITS; i > 0; i--) begin
      if (pend[i-1]) push_idx = IW'(i - 1);
    end
  end

  assign pop  = ev.EV_VALID && ev.EV_READY;
  assign push = (|pend) && ((count != CNTW'(FIFO_DEPTH)) || pop);

  always_comb begin
    push_mask = '0;
    if (push) push_mask[push_idx] = 1'b1;
  end

  // A change lands on an occupied pending slot unless that slot drains on the same edge
  assign ovf_set = |(chg & pend & ~push_mask);

  assign ev.EV_VALID = (count != '0);
  assign ev.EV_DATA  = ev.EV_VALID ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= '0;
      pdir        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      EV_OVERFLOW <= 1'b0;
    end else begin
      pend <= (pend & ~push_mask) | chg;
      pdir <= (pdir & ~chg) | (chg_dir & chg);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (ovf_set) begin
        EV_OVERFLOW <= 1'b1;
      end else if (OVF_CLR) begin
        EV_OVERFLOW <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (push) mem[wr_ptr] <= ev_t'{dir: pdir[push_idx], idx: push_idx};
  end

endmodule

// File: tb/tb_swi_event_capture.sv
// Directed bench for swi_event_capture: debounce latency, glitch rejection, queueing and overflow.
module tb_swi_event_capture;
  import swi_pkg::*;

  logic       clk_2 = 1'b0;
  logic       rst_n;
  logic [7:0] SWI;
  logic [7:0] SWI_STABLE;
  logic [7:0] RISE;
  logic [7:0] FALL;
  logic       EV_OVERFLOW;
  logic       OVF_CLR;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  swi_event_capture_if #(.NBITS(NBITS_TOP)) ev_if ();

  swi_event_capture #(
    .NBITS      (NBITS_TOP),
    .DEB_CYCLES (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_2       (clk_2),
    .rst_n       (rst_n),
    .SWI         (SWI),
    .SWI_STABLE  (SWI_STABLE),
    .RISE        (RISE),
    .FALL        (FALL),
    .ev          (ev_if),
    .EV_OVERFLOW (EV_OVERFLOW),
    .OVF_CLR     (OVF_CLR)
  );

  always #5 clk_2 = ~clk_2;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] evd(input logic d, input int unsigned i);
    swi_ev_t e;
    e.dir = d;
    e.idx = IDX_W'(i);
    return 32'(e);
  endfunction

  // Apply a new switch pattern, check the edge pulses on the debounce edge, then settle
  task automatic step(input logic [7:0] v, input logic [7:0] er, input logic [7:0] ef);
    SWI = v;
    tick(6);
    chk("step_rise",   32'(RISE),       32'(er));
    chk("step_fall",   32'(FALL),       32'(ef));
    chk("step_stable", 32'(SWI_STABLE), 32'(v));
    tick(4);
  endtask

  logic [31:0] drain_exp [5];

  initial begin
    rst_n          = 1'b0;
    SWI            = 8'h00;
    OVF_CLR        = 1'b0;
    ev_if.EV_READY = 1'b0;
    tick(3);
    chk("rst_stable", 32'(SWI_STABLE),        32'h0);
    chk("rst_rise",   32'(RISE),              32'h0);
    chk("rst_fall",   32'(FALL),              32'h0);
    chk("rst_valid",  32'(ev_if.EV_VALID),    32'h0);
    chk("rst_data",   32'(ev_if.EV_DATA),     32'h0);
    chk("rst_ovf",    32'(EV_OVERFLOW),       32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_valid", 32'(ev_if.EV_VALID), 32'h0);
    end
    chk("idle_stable", 32'(SWI_STABLE), 32'h0);

    // Basic rise on bits 0 and 2: stable at k+5, events from k+6
    ev_if.EV_READY = 1'b1;
    SWI = 8'h05;
    tick(5);
    chk("lat_pre_stable", 32'(SWI_STABLE), 32'h00);
    tick(1);
    chk("lat_stable", 32'(SWI_STABLE),     32'h05);
    chk("lat_rise",   32'(RISE),           32'h05);
    chk("lat_fall",   32'(FALL),           32'h00);
    chk("lat_novalid",32'(ev_if.EV_VALID), 32'h0);
    tick(1);
    chk("rise_once",  32'(RISE),           32'h00);
    chk("ev0_valid",  32'(ev_if.EV_VALID), 32'h1);
    chk("ev0_data",   32'(ev_if.EV_DATA),  evd(1'b1, 0));
    tick(1);
    chk("ev1_valid",  32'(ev_if.EV_VALID), 32'h1);
    chk("ev1_data",   32'(ev_if.EV_DATA),  evd(1'b1, 2));
    tick(1);
    chk("ev_empty",   32'(ev_if.EV_VALID), 32'h0);

    // Three-cycle glitch on bit 3 must vanish
    SWI = 8'h0D;
    tick(3);
    SWI = 8'h05;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("gl_stable", 32'(SWI_STABLE),     32'h05);
      chk("gl_rise",   32'(RISE),           32'h00);
      chk("gl_valid",  32'(ev_if.EV_VALID), 32'h0);
    end

    // Backpressure: fill queue, one pending, then a lost change
    ev_if.EV_READY = 1'b0;
    step(8'h07, 8'h02, 8'h00);
    step(8'h05, 8'h00, 8'h02);
    step(8'h07, 8'h02, 8'h00);
    step(8'h05, 8'h00, 8'h02);
    chk("bp_valid", 32'(ev_if.EV_VALID), 32'h1);
    chk("bp_head",  32'(ev_if.EV_DATA),  evd(1'b1, 1));
    chk("bp_ovf0",  32'(EV_OVERFLOW),    32'h0);
    step(8'h07, 8'h02, 8'h00);
    chk("bp_ovf1",  32'(EV_OVERFLOW),    32'h0);
    chk("bp_hold",  32'(ev_if.EV_DATA),  evd(1'b1, 1));
    step(8'h05, 8'h00, 8'h02);
    chk("bp_ovf2",  32'(EV_OVERFLOW),    32'h1);

    // Drain: first pop coincides with the pending push into a full queue
    drain_exp[0] = evd(1'b1, 1);
    drain_exp[1] = evd(1'b0, 1);
    drain_exp[2] = evd(1'b1, 1);
    drain_exp[3] = evd(1'b0, 1);
    drain_exp[4] = evd(1'b0, 1);
    ev_if.EV_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("dr_valid", 32'(ev_if.EV_VALID), 32'h1);
      chk("dr_data",  32'(ev_if.EV_DATA),  drain_exp[i]);
      tick(1);
    end
    chk("dr_empty",  32'(ev_if.EV_VALID), 32'h0);
    chk("dr_sticky", 32'(EV_OVERFLOW),    32'h1);

    // OVF_CLR alone clears; OVF_CLR on the loss edge does not
    OVF_CLR = 1'b1;
    tick(1);
    OVF_CLR = 1'b0;
    chk("clr_ovf", 32'(EV_OVERFLOW), 32'h0);
    tick(1);
    chk("clr_hold", 32'(EV_OVERFLOW), 32'h0);
    ev_if.EV_READY = 1'b0;
    step(8'h07, 8'h02, 8'h00);
    step(8'h05, 8'h00, 8'h02);
    step(8'h07, 8'h02, 8'h00);
    step(8'h05, 8'h00, 8'h02);
    step(8'h07, 8'h02, 8'h00);
    SWI = 8'h05;
    tick(5);
    chk("race_pre", 32'(EV_OVERFLOW), 32'h0);
    OVF_CLR = 1'b1;
    tick(1);
    OVF_CLR = 1'b0;
    chk("race_set_wins", 32'(EV_OVERFLOW), 32'h1);
    tick(4);
    ev_if.EV_READY = 1'b1;
    tick(6);
    chk("race_drained", 32'(ev_if.EV_VALID), 32'h0);

    // Mid-operation reset with three queued events and debounce in flight
    ev_if.EV_READY = 1'b0;
    step(8'h07, 8'h02, 8'h00);
    step(8'h05, 8'h00, 8'h02);
    step(8'h07, 8'h02, 8'h00);
    chk("mr_queued", 32'(ev_if.EV_VALID), 32'h1);
    SWI = 8'hFF;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("mr_valid",  32'(ev_if.EV_VALID), 32'h0);
    chk("mr_data",   32'(ev_if.EV_DATA),  32'h0);
    chk("mr_stable", 32'(SWI_STABLE),     32'h00);
    chk("mr_ovf",    32'(EV_OVERFLOW),    32'h0);
    tick(2);
    ev_if.EV_READY = 1'b1;
    rst_n = 1'b1;
    tick(5);
    chk("ff_pre_stable", 32'(SWI_STABLE),     32'h00);
    chk("ff_pre_valid",  32'(ev_if.EV_VALID), 32'h0);
    tick(1);
    chk("ff_stable", 32'(SWI_STABLE), 32'hFF);
    chk("ff_rise",   32'(RISE),       32'hFF);
    tick(1);
    chk("ff_rise_once", 32'(RISE), 32'h00);
    for (int i = 0; i < 8; i++) begin
      chk("ff_valid", 32'(ev_if.EV_VALID), 32'h1);
      chk("ff_data",  32'(ev_if.EV_DATA),  evd(1'b1, i));
      tick(1);
    end
    chk("ff_empty", 32'(ev_if.EV_VALID), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/swi_event_capture.md
Name: swi_event_capture

Overview:
Input-side counterpart to the display-driving top level: conditions the raw SWI switch bank into clean, debounced levels and queues a discrete event for every debounced transition. The block sits between the simulator-driven SWI pins and user logic. User logic gets stable levels, single-cycle edge pulses and a valid/ready event queue, so no switch toggle is lost while the consumer is busy.

Parameters:
NBITS, 8, number of switch inputs (matches the SWI width of the top level)
DEB_CYCLES, 4, consecutive cycles a synchronized value must differ from the stable value before it is accepted (>=2)
FIFO_DEPTH, 4, event queue entries (power of two)

Ports:
clk_2  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
SWI  input  NBITS  raw switch levels, asynchronous to clk_2
SWI_STABLE  output  NBITS  debounced switch levels
RISE  output  NBITS  one-cycle pulse per bit on debounced 0->1
FALL  output  NBITS  one-cycle pulse per bit on debounced 1->0
EV_VALID  output  1  queue head valid
EV_DATA  output  $clog2(NBITS)+1  {dir, idx}: dir=1 for rise; idx=switch index
EV_READY  input  1  consumer accepts head
EV_OVERFLOW  output  1  sticky: a debounced change was lost
OVF_CLR  input  1  clears EV_OVERFLOW

Behaviour:
- Reset (rst_n low, async): sync flops, SWI_STABLE, RISE, FALL, debounce counters, pending mask, FIFO pointers/count and EV_OVERFLOW all go to 0. EV_VALID=0 and EV_DATA=0. No events are generated for switches that are already high at reset release; they must first debounce 0->1.
- Synchronizer: two flops per bit.
- Debounce per bit:
  - If sync2 != stable, cnt increments.
  - When cnt == DEB_CYCLES-1 and values still differ: stable <= sync2 and cnt <= 0.
  - If sync2 == stable at any edge: cnt <= 0. A glitch shorter than DEB_CYCLES therefore produces nothing.
- Latency: SWI new value first sampled at edge k -> SWI_STABLE changes at edge k+DEB_CYCLES+1.
- RISE/FALL: registered; asserted for exactly one cycle, coincident with the new SWI_STABLE value.
- Pending stage:
  - A debounced change on bit i sets pend[i] and records pdir[i].
  - If pend[i] is already set at that moment: EV_OVERFLOW<=1, pdir[i] is overwritten, and one event is kept.
- Push arbitration:
  - Each edge, if FIFO count<FIFO_DEPTH or a pop occurs at the same edge, the lowest pending index is pushed and its pend bit cleared.
  - At most one push per cycle.
  - If bit i is pushed on the same edge as a new change on bit i: the new change re-sets pend[i], and no overflow is flagged.
- FIFO:
  - EV_VALID = count!=0.
  - EV_DATA = head entry, held stable while EV_VALID && !EV_READY.
  - Pop on EV_VALID && EV_READY.
  - Push and pop in the same cycle leave count unchanged, including when full.
  - Pointers wrap modulo FIFO_DEPTH.
- Event latency: push occurs at edge k+DEB_CYCLES+2 when there is space. EV_VALID is high after that edge.
- EV_OVERFLOW: sticky. OVF_CLR clears it, but a set condition in the same cycle wins.
- Mid-operation reset discards all queued and pending events.

Decomposition:
- Package swi_pkg holds:
  - NBITS_TOP (=8)
  - IDX_W = $clog2(NBITS_TOP)
  - typedef struct packed {logic dir; logic [IDX_W-1:0] idx;} swi_ev_t
- Sub-module swi_debounce_bit: one bit's synchronizer, counter and stable/rise/fall regs, instantiated NBITS times via generate.
- The FIFO and arbiter stay in the top of this block.

Test Plan:
- Reset, then SWI=8'h00: all outputs 0 and EV_VALID stays 0 for 20 cycles. Then set SWI=8'h05 at edge k: SWI_STABLE=8'h05 at edge k+5, RISE=8'h05 for one cycle, then events {1,0} and {1,2} in that order, with EV_READY=1.
- Glitch: SWI[3] high for 3 cycles (<DEB_CYCLES) -> SWI_STABLE, RISE and EV_VALID unchanged.
- Backpressure: EV_READY=0; toggle SWI[1] 0->1->0->1->0 with 10-cycle holds -> 4 events queued. Then toggle SWI[1] to 1 -> pending holds it. Toggle back to 0 -> EV_OVERFLOW=1. Raise EV_READY -> drain order: {1,1},{0,1},{1,1},{0,1},{0,1}.
- Full + simultaneous: FIFO full and EV_READY=1 on the same edge as a pending push -> count stays 4 and ordering is preserved.
- OVF_CLR pulse with no new loss -> EV_OVERFLOW=0. OVF_CLR asserted on the same edge as a loss -> EV_OVERFLOW stays 1.
- Assert rst_n=0 mid-debounce with 3 events queued -> EV_VALID=0 immediately (async). After release, with SWI held at 8'hFF: RISE=8'hFF once, and 8 events come out in index order 0..7.
